uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning entries in the transmit buffer; power of 2, at least 2.
REQ-003 SHALL have parameter PRESCALE_W, default 8, meaning width of the bit-period prescale input.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port data_valid, input, 1 bit: write request for p_data.
REQ-007 SHALL have port p_data, input, DATA_WIDTH bits: payload, LSB transmitted first.
REQ-008 SHALL have port par_en, input, 1 bit: 1 adds a parity bit to the frame.
REQ-009 SHALL have port par_typ, input, 1 bit: 1 selects odd parity, 0 selects even.
REQ-010 SHALL have port stop2, input, 1 bit: 1 sends two stop bits, 0 sends one.
REQ-011 SHALL have port prescale, input, PRESCALE_W bits: clocks per bit minus 1.
REQ-012 SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-013 SHALL have port busy, output, 1 bit: high while any frame bit is on the line.
REQ-014 SHALL have port ready, output, 1 bit: buffer can accept a write this cycle.
REQ-015 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of occupied entries.
REQ-016 SHALL have port overflow, output, 1 bit: one-cycle pulse when a write is dropped.

Function
REQ-017 SHALL accept a write at a posedge where data_valid=1 and ready=1, storing {p_data, par_en, par_typ, stop2} as one entry.
REQ-018 SHALL drive ready = (fifo_count < FIFO_DEPTH); a pop in the same cycle does not unblock a write when the buffer is full.
REQ-019 SHALL drop a write with data_valid=1 and ready=0, leave state unchanged, and pulse overflow high for exactly the next cycle.
REQ-020 SHALL use an FSM with states IDLE, START, DATA, PARITY and STOP, from a shared package enum.
REQ-021 IDLE -> START at the first posedge where the buffer is non-empty; pop the entry; latch it and prescale into frame registers.
REQ-022 SHALL register tx_out; the start bit (0) is visible one cycle after the accepting posedge when IDLE with an empty buffer.
REQ-023 SHALL hold every bit for prescale+1 clocks; prescale=0 sends one bit per clock.
REQ-024 SHALL send frame order start(0), DATA_WIDTH data bits LSB first, parity if latched par_en=1, then 1 or 2 stop bits(1).
REQ-025 SHALL compute parity over the latched data: even = ^data, odd = ~^data.
REQ-026 STOP -> START directly with no idle cycle if the buffer is non-empty at the end of the last stop bit; otherwise STOP -> IDLE.
REQ-027 SHALL assert busy registered, aligned exactly with the start bit through the last stop bit; it stays high across back-to-back frames.
REQ-028 SHALL ignore changes to par_en, par_typ, stop2 and prescale on the line in use; they apply only to entries or frames not yet started.
REQ-029 SHALL handle pointers that wrap modulo FIFO_DEPTH; simultaneous push and pop (not full) leaves fifo_count unchanged.

Reset
REQ-030 With rst=0, SHALL immediately force tx_out=1, busy=0, overflow=0, fifo_count=0, ready=1, FSM=IDLE and pointers 0.
REQ-031 SHALL abort any frame in progress and discard buffered entries when reset is asserted mid-frame; no partial frame resumes.

Configuration
REQ-032 Macro UART_TX_PARAM_FIFO_EN defined: the buffer is FIFO_DEPTH entries deep.
REQ-033 Macro UART_TX_PARAM_FIFO_EN undefined: a single holding register is used (effective depth 1); ready=1 only when it is empty; fifo_count is 0 or 1; all other behaviour is identical.

Structure
REQ-034 Package uart_tx_pkg SHALL hold the FSM state enum, the PARITY_EVEN/PARITY_ODD constants and the frame-entry struct width.
REQ-035 SHALL split out sub-module uart_tx_fifo (synchronous FIFO with count, full and empty), instantiated only under UART_TX_PARAM_FIFO_EN.

Verification
REQ-036 Write 8'hFF with par_en=0, prescale=0 -> tx_out sequence 0,1x8,1; busy high for 10 cycles.
REQ-037 Write 8'h00 with par_en=1, par_typ=1, prescale=3 -> frame 0,0x8,1,1 with each bit 4 clocks; busy high for 44 cycles.
REQ-038 Write 8'hA5 (odd parity, stop2=1) then 8'h3C (even parity, stop2=0) back-to-back, prescale=0 -> 12-bit then 11-bit frame with no idle gap; parity bits 1 then 0.
REQ-039 Issue 6 writes while the first frame is on the line, FIFO_DEPTH=4 -> ready low at count 4; one overflow pulse; the 5 accepted frames are sent in order.
REQ-040 Assert rst=0 in the middle of the data bits -> tx_out=1, busy=0 and fifo_count=0 with no clock edge; the next write produces a clean frame.
REQ-041 Hold data_valid=0 for 20 cycles after reset -> tx_out stays 1 and busy stays 0 throughout.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the parameterised UART transmitter.
//   - tx_state_t   : transmitter FSM states
//   - PARITY_EVEN / PARITY_ODD : encodings of the par_typ input
//   - tx_entry_t   : one buffered frame request (data + per-frame options)
//   - TX_ENTRY_W   : width of a buffered entry in bits
//   - parity_bit() : parity over a latched data word
// Build option: UART_TX_PARAM_FIFO_EN (selects the multi-entry buffer in
// uart_tx_param; nothing in this package depends on it).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Entries are sized for the widest legal frame; narrower data is
  // zero-extended, which leaves the XOR parity unchanged.
  localparam int DATA_MAX_W = 9;
  localparam int BIT_IDX_W  = 4;

  typedef struct packed {
    logic [DATA_MAX_W-1:0] data;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
  } tx_entry_t;

  localparam int TX_ENTRY_W = $bits(tx_entry_t);

  function automatic logic parity_bit(input logic [DATA_MAX_W-1:0] d,
                                      input logic                  typ);
    return (typ == PARITY_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: write-side handshake of the UART transmitter.
//   data_valid  : write request (master -> slave)
//   p_data      : payload, DATA_WIDTH bits (master -> slave)
//   ready       : buffer can take a write this cycle (slave -> master)
//   fifo_count  : occupied buffer entries (slave -> master)
//   overflow    : one-cycle pulse after a dropped write (slave -> master)
// Build option: UART_TX_PARAM_FIFO_EN (affects only the slave behaviour).
interface uart_tx_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  data_valid;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  ready;
  logic [CNT_W-1:0]      fifo_count;
  logic                  overflow;

  modport master (
    output data_valid, p_data,
    input  ready, fifo_count, overflow
  );

  modport slave (
    input  data_valid, p_data,
    output ready, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with occupancy count, full and empty flags.
//   clk, rst   : clock, asynchronous active-low reset
//   push_i     : write wr_data_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   wr_data_i  : entry to write
//   rd_data_o  : current head entry (combinational read)
//   count_o    : occupied entries, 0..DEPTH
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
// Only instantiated when UART_TX_PARAM_FIFO_EN is defined.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = TX_ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Head is read without a register so the transmitter can latch the entry
  // in the same cycle it pops it.
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter with per-frame parity/stop options.
//   clk       : clock, all logic on posedge
//   rst       : asynchronous active-low reset
//   bus       : write handshake (data_valid, p_data, ready, fifo_count,
//               overflow), slave side of uart_tx_param_if
//   par_en    : add a parity bit to the frame being written
//   par_typ   : 1 odd parity, 0 even parity
//   stop2     : 1 two stop bits, 0 one stop bit
//   prescale  : clocks per bit minus 1, sampled when a frame starts
//   tx_out    : registered serial line, idle high
//   busy      : registered, high from start bit through last stop bit
// Build option: UART_TX_PARAM_FIFO_EN defined -> FIFO_DEPTH-entry buffer;
// undefined -> single holding register.
module uart_tx_param
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_param_if.slave        bus,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------- write buffer ----------------
  tx_entry_t        wr_entry, head;
  logic             push, pop;
  logic             buf_full, buf_empty;
  logic [CNT_W-1:0] count;
  logic             overflow_q;

  assign wr_entry = '{data:    DATA_MAX_W'(bus.p_data),
                      par_en:  par_en,
                      par_typ: par_typ,
                      stop2:   stop2};

  // Readiness is judged on the occupancy before this cycle's pop, so a full
  // buffer stays closed even when the transmitter pops on the same edge.
  assign push = bus.data_valid & ~buf_full;

`ifdef UART_TX_PARAM_FIFO_EN
  logic [TX_ENTRY_W-1:0] head_bits;

  uart_tx_fifo #(
    .WIDTH (TX_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i (wr_entry),
    .rd_data_o (head_bits),
    .count_o   (count),
    .full_o    (buf_full),
    .empty_o   (buf_empty)
  );

  assign head = head_bits;
`else
  tx_entry_t hold_q;
  logic      hold_valid_q;

  // Push needs an empty register and pop a full one, so they never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      if (push) hold_q <= wr_entry;
      hold_valid_q <= push | (hold_valid_q & ~pop);
    end
  end

  assign head      = hold_q;
  assign buf_full  = hold_valid_q;
  assign buf_empty = ~hold_valid_q;
  assign count     = CNT_W'(hold_valid_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else      overflow_q <= bus.data_valid & buf_full;
  end

  assign bus.ready      = ~buf_full;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;

  // ---------------- transmit FSM ----------------
  tx_state_t             state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [BIT_IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_MAX_W-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_done;
  logic                  load;

  assign bit_done = (cnt_q == prescale_q);

  // tx_d/busy_d carry the value of the bit being entered, so the registered
  // line changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prescale_d = prescale_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    load       = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!buf_empty) load = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == BIT_IDX_W'(DATA_WIDTH - 1)) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + BIT_IDX_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          // idx counts stop bits already sent.
          if (stop2_q && idx_q == '0) begin
            idx_d = BIT_IDX_W'(1);
            tx_d  = 1'b1;
          end else if (!buf_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Start a frame: pop the head and freeze all its options and the
    // prescale, so later input changes only affect later frames.
    if (load) begin
      pop        = 1'b1;
      state_d    = START;
      cnt_d      = '0;
      idx_d      = '0;
      shift_d    = head.data;
      parity_d   = parity_bit(head.data, head.par_typ);
      par_en_d   = head.par_en;
      stop2_d    = head.stop2;
      prescale_d = prescale;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prescale_q <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prescale_q <= prescale_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed self-checking bench for uart_tx_param.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected buffer behaviour follows UART_TX_PARAM_FIFO_EN (depth 4 when
// defined, single holding register otherwise).
module tb_uart_tx_param;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 8;
`ifdef UART_TX_PARAM_FIFO_EN
  localparam int EFF_DEPTH = DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          par_en, par_typ, stop2;
  logic [PW-1:0] prescale;
  logic          tx_out, busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_param_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_param #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .PRESCALE_W (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .par_en   (par_en),
    .par_typ  (par_typ),
    .stop2    (stop2),
    .prescale (prescale),
    .tx_out   (tx_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one write for one cycle; returns on the following falling edge.
  task automatic write(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    bus.data_valid = 1'b1;
    bus.p_data     = d;
    par_en         = pe;
    par_typ        = pt;
    stop2          = s2;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  // Call on the first falling edge of the start bit; returns on the first
  // falling edge after the last stop bit.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic pbit, input logic s2, input int ps);
    logic [11:0] seq;
    int          n;
    seq = '1;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[1+i] = d[i];
    n = 9;
    if (pe) begin
      seq[n] = pbit;
      n++;
    end
    n++;
    if (s2) n++;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c <= ps; c++) begin
        check($sformatf("%s_tx_bit%0d_clk%0d", tag, b, c), tx_out, seq[b]);
        check($sformatf("%s_busy_bit%0d_clk%0d", tag, b, c), busy, 1'b1);
        @(negedge clk);
      end
    end
    $display("TXN %s data=0x%02h bits=%0d clocks_per_bit=%0d", tag, d, n, ps + 1);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check($sformatf("%s_tx_%0d", tag, i), tx_out, 1'b1);
      check($sformatf("%s_busy_%0d", tag, i), busy, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n;
    n = 0;
    while (tx_out !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, tx_out, 1'b0);
  endtask

  logic [7:0] burst_d [6];
  logic       exp_drop [6];
  int         exp_cnt [6];
  logic [7:0] acc [5];
  int         n_acc;

  initial begin
    bus.data_valid = 1'b0;
    bus.p_data     = '0;
    par_en         = 1'b0;
    par_typ        = 1'b0;
    stop2          = 1'b0;
    prescale       = '0;
    rst            = 1'b1;

    // Reset state, before any clock edge.
    #1 rst = 1'b0;
    #1;
    check("rst_tx", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ready", bus.ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Quiet line for 20 cycles.
    idle_check("idle20", 20);

    // 0xFF, no parity, one stop, one clock per bit.
    prescale = 8'd0;
    write(8'hFF, 1'b0, 1'b0, 1'b0);
    check("ff_count_stored", bus.fifo_count, 1);
    check("ff_tx_latency", tx_out, 1'b1);
    @(negedge clk);
    expect_frame("ff", 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    idle_check("after_ff", 2);

    // 0x00, odd parity (=1), 4 clocks per bit; options change mid-frame.
    prescale = 8'd3;
    write(8'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    prescale = 8'd0;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    stop2    = 1'b1;
    expect_frame("00_odd", 8'h00, 1'b1, 1'b1, 1'b0, 3);
    idle_check("after_00", 2);

    // 0xA5 odd parity (=1) two stops, then 0x3C even parity (=0) one stop.
    prescale = 8'd0;
    write(8'hA5, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    fork
      write(8'h3C, 1'b1, 1'b0, 1'b0);
      begin
        expect_frame("a5", 8'hA5, 1'b1, 1'b1, 1'b1, 0);
        expect_frame("3c", 8'h3C, 1'b1, 1'b0, 1'b0, 0);
      end
    join
    idle_check("after_b2b", 2);

    // Six consecutive writes while the first frame goes out.
    burst_d[0] = 8'h01; burst_d[1] = 8'h80; burst_d[2] = 8'h5A;
    burst_d[3] = 8'hC3; burst_d[4] = 8'h0F; burst_d[5] = 8'hF0;
`ifdef UART_TX_PARAM_FIFO_EN
    exp_drop[0] = 0; exp_drop[1] = 0; exp_drop[2] = 0;
    exp_drop[3] = 0; exp_drop[4] = 0; exp_drop[5] = 1;
    exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 2;
    exp_cnt[3] = 3; exp_cnt[4] = 4; exp_cnt[5] = 4;
    acc[0] = 8'h01; acc[1] = 8'h80; acc[2] = 8'h5A; acc[3] = 8'hC3; acc[4] = 8'h0F;
    n_acc = 5;
`else
    exp_drop[0] = 0; exp_drop[1] = 1; exp_drop[2] = 0;
    exp_drop[3] = 1; exp_drop[4] = 1; exp_drop[5] = 1;
    exp_cnt[0] = 1; exp_cnt[1] = 0; exp_cnt[2] = 1;
    exp_cnt[3] = 1; exp_cnt[4] = 1; exp_cnt[5] = 1;
    acc[0] = 8'h01; acc[1] = 8'h5A; acc[2] = 8'h00; acc[3] = 8'h00; acc[4] = 8'h00;
    n_acc = 2;
`endif
    prescale = 8'd3;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    stop2    = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus.data_valid = 1'b1;
          bus.p_data     = burst_d[i];
          @(negedge clk);
          check($sformatf("burst_overflow_w%0d", i), bus.overflow, exp_drop[i]);
          check($sformatf("burst_count_w%0d", i), bus.fifo_count, exp_cnt[i]);
          check($sformatf("burst_ready_w%0d", i), bus.ready, (exp_cnt[i] < EFF_DEPTH));
        end
        bus.data_valid = 1'b0;
        @(negedge clk);
        check("burst_overflow_end", bus.overflow, 1'b0);
      end
      begin
        wait_start("burst", 10);
        for (int k = 0; k < n_acc; k++)
          expect_frame($sformatf("burst%0d", k), acc[k], 1'b0, 1'b0, 1'b0, 3);
      end
    join
    idle_check("after_burst", 3);
    check("burst_count_empty", bus.fifo_count, 0);

    // Reset in the middle of the data bits, with one entry still buffered.
    prescale = 8'd1;
    write(8'h5A, 1'b0, 1'b0, 1'b0);
    wait_start("rst_mid", 10);
    write(8'h3C, 1'b0, 1'b0, 1'b0);
    check("rst_mid_count", bus.fifo_count, 1);
    repeat (5) @(negedge clk);
    check("rst_mid_tx_bit2", tx_out, 1'b0);
    check("rst_mid_busy", busy, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_tx", tx_out, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_count", bus.fifo_count, 0);
    check("async_rst_ready", bus.ready, 1'b1);
    check("async_rst_overflow", bus.overflow, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle_check("post_rst", 6);
    check("post_rst_count", bus.fifo_count, 0);

    // Clean frame after reset: 0x96 even parity (=0).
    write(8'h96, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_frame("96_even", 8'h96, 1'b1, 1'b0, 1'b0, 1);
    idle_check("after_96", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
